// File: rtl/ica_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ica_ctrl_pkg
// Shared definitions for the FastICA one-unit iteration sequencer.
//   seq_state_e      : sequencer state encoding
//   NSamplesDefault  : default number of batches accepted per iteration
//   MaxIterDefault   : default iteration limit
//   clog2_min1()     : $clog2 clamped to at least 1, for counter widths
// ----------------------------------------------------------------------------
package ica_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StStream = 3'd2,
        StDrain  = 3'd3,
        StUpdate = 3'd4,
        StDone   = 3'd5
    } seq_state_e;

    localparam int unsigned NSamplesDefault = 1024;
    localparam int unsigned MaxIterDefault  = 64;

    // A counter over a single value still needs one bit of storage.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/one_unit_seq_if.sv
// ----------------------------------------------------------------------------
// one_unit_seq_if
// Control bundle between the one-unit sequencer and its surroundings.
//   master modport : source/host side (drives start, abort, z_valid,
//                    upd_done, converged; observes everything else)
//   slave modport  : sequencer side
//   IT_W           : width of the completed-iteration counter
// ----------------------------------------------------------------------------
interface one_unit_seq_if
    import ica_ctrl_pkg::*;
#(
    parameter int unsigned IT_W = clog2_min1(MaxIterDefault + 1)
);

    // Run control
    logic            start;
    logic            abort;
    // Batch handshake
    logic            z_valid;
    logic            z_ready;
    // Multiplier stage enables
    logic            en_mul1;
    logic            en_mul2;
    logic            en_mul3;
    // Accumulator control
    logic            acc_clr;
    logic            acc_en;
    logic            acc_last;
    // Weight-update handoff
    logic            upd_start;
    logic            upd_done;
    logic            converged;
    // Status
    logic            busy;
    logic            done;
    logic            timeout;
    logic [IT_W-1:0] iter_cnt;

    modport master (
        output start, abort, z_valid, upd_done, converged,
        input  z_ready, en_mul1, en_mul2, en_mul3, acc_clr, acc_en, acc_last,
        input  upd_start, busy, done, timeout, iter_cnt
    );

    modport slave (
        input  start, abort, z_valid, upd_done, converged,
        output z_ready, en_mul1, en_mul2, en_mul3, acc_clr, acc_en, acc_last,
        output upd_start, busy, done, timeout, iter_cnt
    );

endinterface

// File: rtl/one_unit_vpipe.sv
// ----------------------------------------------------------------------------
// one_unit_vpipe
// Three-deep valid/last token shift register that follows a batch through
// MUL2, MUL3 and the accumulator.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of every stage
//   valid_i       : token entering (MUL1 enable)
//   last_i        : token is the last batch of the iteration
//   v2_o, v3_o    : MUL2 / MUL3 stage valid
//   va_o          : accumulator stage valid
//   last_a_o      : last flag of the accumulator stage
//   empty_o       : no token in any stage
// ----------------------------------------------------------------------------
module one_unit_vpipe (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic valid_i,
    input  logic last_i,
    output logic v2_o,
    output logic v3_o,
    output logic va_o,
    output logic last_a_o,
    output logic empty_o
);

    // Bit 0 = MUL2 stage, bit 1 = MUL3 stage, bit 2 = accumulator stage.
    logic [2:0] valid_q, valid_d;
    logic [2:0] last_q,  last_d;

    always_comb begin
        valid_d = {valid_q[1:0], valid_i};
        // A bubble never carries a last flag.
        last_d  = {last_q[1:0], valid_i & last_i};
        if (flush_i) begin
            valid_d = '0;
            last_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign v2_o     = valid_q[0];
    assign v3_o     = valid_q[1];
    assign va_o     = valid_q[2];
    assign last_a_o = last_q[2];
    assign empty_o  = ~|valid_q;

endmodule

// File: rtl/one_unit_seq.sv
// ----------------------------------------------------------------------------
// one_unit_seq
// Sequencer for the FastICA one-unit iteration datapath. Streams N_SAMPLES
// whitened batches per iteration into the MUL1/MUL2/MUL3 chain as a travelling
// valid token, frames each iteration with an accumulator clear and a last
// marker, hands off to the weight-update unit and loops until convergence or
// MAX_ITER iterations.
//   clk_mul : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : one_unit_seq_if.slave (handshake, enables, status)
// Parameters:
//   N_SAMPLES : batches per iteration (>= 1)
//   MAX_ITER  : iteration limit (>= 1)
//   CNT_W     : batch counter width
//   IT_W      : iteration counter width (must match the interface)
// ----------------------------------------------------------------------------
module one_unit_seq
    import ica_ctrl_pkg::*;
#(
    parameter int unsigned N_SAMPLES = NSamplesDefault,
    parameter int unsigned MAX_ITER  = MaxIterDefault,
    parameter int unsigned CNT_W     = clog2_min1(N_SAMPLES),
    parameter int unsigned IT_W      = clog2_min1(MAX_ITER + 1)
) (
    input  logic          clk_mul,
    input  logic          rst_n,
    one_unit_seq_if.slave bus
);

    seq_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IT_W-1:0]  iter_q, iter_d;
    logic [IT_W-1:0]  iter_inc;

    // Registered outputs, each derived from the next state.
    logic z_ready_q, z_ready_d;
    logic acc_clr_q, acc_clr_d;
    logic busy_q,    busy_d;
    logic done_q,    done_d;
    logic timeout_q, timeout_d;

    logic accept;
    logic last_accept;
    logic upd_start;

    logic v2, v3, va, last_a, pipe_empty;

    // Abort kills the handshake in its own cycle so no batch is half-accepted.
    assign accept      = bus.z_valid & z_ready_q & ~bus.abort;
    assign last_accept = accept && (cnt_q == CNT_W'(N_SAMPLES - 1));
    assign iter_inc    = iter_q + IT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        iter_d    = iter_q;
        timeout_d = timeout_q;
        upd_start = 1'b0;

        if (bus.abort) begin
            state_d = StIdle;
            cnt_d   = '0;
            iter_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d   = StClear;
                        iter_d    = '0;
                        timeout_d = 1'b0;
                    end
                end
                StClear: begin
                    cnt_d   = '0;
                    state_d = StStream;
                end
                StStream: begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_accept) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    // The update unit may only start once the last product
                    // has been folded into the accumulator.
                    if (pipe_empty) begin
                        upd_start = 1'b1;
                        state_d   = StUpdate;
                    end
                end
                StUpdate: begin
                    if (bus.upd_done) begin
                        iter_d = iter_inc;
                        if (bus.converged) begin
                            state_d   = StDone;
                            timeout_d = 1'b0;
                        end else if (iter_inc == IT_W'(MAX_ITER)) begin
                            state_d   = StDone;
                            timeout_d = 1'b1;
                        end else begin
                            state_d = StClear;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        z_ready_d = (state_d == StStream);
        acc_clr_d = (state_d == StClear);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk_mul or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            iter_q    <= '0;
            z_ready_q <= 1'b0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            iter_q    <= iter_d;
            z_ready_q <= z_ready_d;
            acc_clr_q <= acc_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    one_unit_vpipe u_vpipe (
        .clk_i    (clk_mul),
        .rst_ni   (rst_n),
        .flush_i  (bus.abort),
        .valid_i  (accept),
        .last_i   (last_accept),
        .v2_o     (v2),
        .v3_o     (v3),
        .va_o     (va),
        .last_a_o (last_a),
        .empty_o  (pipe_empty)
    );

    assign bus.z_ready   = z_ready_q & ~bus.abort;
    assign bus.en_mul1   = accept;
    assign bus.en_mul2   = v2;
    assign bus.en_mul3   = v3;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.acc_en    = va;
    assign bus.acc_last  = va & last_a;
    assign bus.upd_start = upd_start;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.iter_cnt  = iter_q;

endmodule

// File: tb/tb_one_unit_seq.sv
// ----------------------------------------------------------------------------
// tb_one_unit_seq
// Self-checking bench for one_unit_seq with N_SAMPLES=4, MAX_ITER=3.
// ----------------------------------------------------------------------------
module tb_one_unit_seq;
    import ica_ctrl_pkg::*;

    localparam int unsigned NS   = 4;
    localparam int unsigned MI   = 3;
    localparam int unsigned IT_W = clog2_min1(MI + 1);

    logic clk_mul = 1'b0;
    logic rst_n   = 1'b0;

    one_unit_seq_if #(.IT_W(IT_W)) bus ();

    one_unit_seq #(
        .N_SAMPLES (NS),
        .MAX_ITER  (MI)
    ) dut (
        .clk_mul (clk_mul),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_mul = ~clk_mul;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_clr  = 0;
    int n_done = 0;

    // Token scoreboard: due cycle of acc_en and its expected last flag.
    typedef struct {
        int   due;
        logic last;
    } tok_t;
    tok_t sb_q[$];

    logic acc_d1   = 1'b0;
    logic acc_d2   = 1'b0;
    logic prev_acc = 1'b0;
    logic prev_ab  = 1'b0;

    typedef struct {
        logic            st;
        logic            zv;
        logic            ud;
        logic            cv;
        logic            ab;
        logic            lst;
        logic [10:0]     exp_o;
        logic [IT_W-1:0] exp_it;
    } vec_t;
    vec_t tbl[13];

    function automatic logic [10:0] out_vec();
        return {bus.z_ready, bus.en_mul1, bus.en_mul2, bus.en_mul3, bus.acc_clr,
                bus.acc_en, bus.acc_last, bus.upd_start, bus.busy, bus.done,
                bus.timeout};
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        acc_d1   = 1'b0;
        acc_d2   = 1'b0;
        prev_acc = 1'b0;
        prev_ab  = 1'b0;
        sb_q.delete();
    endtask

    // One clock cycle: drive inputs after the edge, check the token pipe mid-cycle.
    task automatic step(input logic st, input logic zv, input logic ud, input logic cv,
                        input logic ab, input logic exp_acc, input logic exp_last);
        @(posedge clk_mul);
        #1;
        cyc++;
        if (prev_ab) begin
            acc_d1 = 1'b0;
            acc_d2 = 1'b0;
            sb_q.delete();
        end else begin
            acc_d2 = acc_d1;
            acc_d1 = prev_acc;
        end
        bus.start     = st;
        bus.z_valid   = zv;
        bus.upd_done  = ud;
        bus.converged = cv;
        bus.abort     = ab;
        @(negedge clk_mul);
        check("en_mul1", 32'(bus.en_mul1), 32'(exp_acc));
        check("en_mul2", 32'(bus.en_mul2), 32'(acc_d1));
        check("en_mul3", 32'(bus.en_mul3), 32'(acc_d2));
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            check("acc_en_tok", 32'({bus.acc_en, bus.acc_last}), 32'({1'b1, sb_q[0].last}));
            void'(sb_q.pop_front());
        end else begin
            check("acc_en_idle", 32'({bus.acc_en, bus.acc_last}), 32'(0));
        end
        if (exp_acc) sb_q.push_back('{due: cyc + 3, last: exp_last});
        n_clr  += int'(bus.acc_clr);
        n_done += int'(bus.done);
        prev_acc = exp_acc;
        prev_ab  = ab;
    endtask

    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].st, tbl[i].zv, tbl[i].ud, tbl[i].cv, tbl[i].ab,
                 tbl[i].exp_o[9], tbl[i].lst);
            check("tbl_out", 32'(out_vec()), 32'(tbl[i].exp_o));
            check("tbl_iter", 32'(bus.iter_cnt), 32'(tbl[i].exp_it));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [6];

        // Continuous stream, converged on the first update.
        //                st    zv    ud    cv    ab    lst   zr e1 e2 e3 clr ae al us bsy dn to
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00000000000, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00001000100, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b11000000100, 2'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b11100000100, 2'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b11110000100, 2'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 11'b11110100100, 2'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00110100100, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00010100100, 2'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00000110100, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00000001100, 2'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'b00000000100, 2'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00000000110, 2'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00000000000, 2'd1};

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

        bus.start = 1'b0; bus.abort = 1'b0; bus.z_valid = 1'b0;
        bus.upd_done = 1'b0; bus.converged = 1'b0;

        // Reset state
        #12;
        check("reset_out", 32'(out_vec()), 32'(0));
        check("reset_iter", 32'(bus.iter_cnt), 32'(0));
        @(negedge clk_mul);
        rst_n = 1'b1;

        // Continuous stream
        run_table();

        // Bubbles: tokens on pattern 1,0,1,1,0,1, last on the 4th token
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("bub_clr", 32'(bus.acc_clr), 32'(1));
        for (int i = 0; i < 6; i++) step(0, pat[i], 0, 1, 0, pat[i], logic'(i == 5));
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            check("bub_upd_start", 32'(bus.upd_start), 32'(k == 4));
        end
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("bub_done", 32'({bus.done, bus.timeout, bus.iter_cnt}), 32'({1'b1, 1'b0, 2'd1}));
        step(0, 0, 0, 1, 0, 0, 0);
        check("bub_idle_busy", 32'(bus.busy), 32'(0));

        // Timeout: never converges; upd_done with upd_start is ignored
        step(1, 0, 0, 0, 0, 0, 0);
        n_clr  = 0;
        n_done = 0;
        for (int it = 0; it < 3; it++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("to_clr", 32'(bus.acc_clr), 32'(1));
            if (it == 0) check("to_iter_cleared", 32'(bus.iter_cnt), 32'(0));
            for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 1, logic'(k == 3));
            for (int k = 1; k <= 4; k++) begin
                step(0, 0, logic'(it == 0 && k == 4), 0, 0, 0, 0);
                check("to_upd_start", 32'(bus.upd_start), 32'(k == 4));
            end
            step(0, 0, 1, 0, 0, 0, 0);
            check("to_in_update", 32'({bus.busy, bus.acc_clr, bus.done}), 32'(3'b100));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        check("to_done", 32'({bus.done, bus.timeout, bus.iter_cnt}), 32'({1'b1, 1'b1, 2'd3}));
        check("to_clr_count", 32'(n_clr), 32'(3));
        check("to_done_count", 32'(n_done), 32'(1));
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("to_held", 32'({bus.busy, bus.timeout, bus.iter_cnt}), 32'({1'b0, 1'b1, 2'd3}));
        end
        step(1, 0, 0, 0, 0, 0, 0);
        check("to_held_at_start", 32'(bus.timeout), 32'(1));
        step(0, 0, 0, 0, 0, 0, 0);
        check("to_cleared_by_start",
              32'({bus.acc_clr, bus.timeout, bus.iter_cnt}), 32'({1'b1, 1'b0, 2'd0}));

        // Abort mid-DRAIN with one token in flight
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 1, 0, 0);
        check("ab_drain_busy", 32'({bus.z_ready, bus.busy}), 32'(2'b01));
        step(0, 0, 0, 0, 0, 0, 0);
        check("ab_after", 32'({bus.busy, bus.acc_en, bus.iter_cnt}), 32'(0));
        n_done = 0;
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0, 0, 0);
        check("ab_no_done", 32'(n_done), 32'(0));
        run_table();

        // Spurious start and upd_done during STREAM
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0, 1, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        check("sp_stream_held", 32'({bus.z_ready, bus.busy, bus.acc_clr}), 32'(3'b110));
        step(0, 1, 0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0, 1, 1);
        step(0, 1, 0, 1, 0, 0, 0);
        check("sp_drain_ready", 32'(bus.z_ready), 32'(0));
        for (int k = 2; k <= 4; k++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            check("sp_upd_start", 32'(bus.upd_start), 32'(k == 4));
        end
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("sp_done", 32'({bus.done, bus.timeout, bus.iter_cnt}), 32'({1'b1, 1'b0, 2'd1}));

        // Asynchronous reset mid-STREAM
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0, 1, 0);
        check("rs_streaming", 32'({bus.z_ready, bus.en_mul1, bus.busy}), 32'(3'b111));
        @(posedge clk_mul);
        #3;
        rst_n = 1'b0;
        #1;
        check("rs_async_out", 32'(out_vec()), 32'(0));
        check("rs_async_iter", 32'(bus.iter_cnt), 32'(0));
        @(negedge clk_mul);
        @(negedge clk_mul);
        bus.z_valid = 1'b0;
        rst_n = 1'b1;
        clear_model();
        step(0, 0, 0, 0, 0, 0, 0);
        check("rs_idle", 32'({bus.busy, bus.z_ready, bus.acc_clr}), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/one_unit_seq.md
# one_unit_seq

Sequencer for the FastICA one-unit iteration datapath. Accepts whitened-sample batches by valid/ready and drives the enables of the three multiplier stages (MUL1 zTw, MUL2 (zTw)^2, MUL3 (zTw)^3) as a travelling valid token. Frames each iteration with accumulator clear and last-batch markers, hands off to the weight-update/normalise unit, and repeats until convergence or an iteration limit.

## Interface
Parameters:
- N_SAMPLES, 1024 — batches accepted per iteration (≥1)
- MAX_ITER, 64 — iteration limit (≥1)
- CNT_W, $clog2(N_SAMPLES) — batch counter width
- IT_W, $clog2(MAX_ITER+1) — iteration counter width

Ports:
- clk_mul  in  1  — single clock, rising edge
- rst_n  in  1  — asynchronous active-low reset
- start  in  1  — begin a run; sampled only in IDLE
- abort  in  1  — synchronous abort; overrides everything except reset
- z_valid  in  1  — source has a batch
- z_ready  out  1  — sequencer accepts a batch
- en_mul1 / en_mul2 / en_mul3  out  1 each  — stage enables
- acc_clr  out  1  — one-cycle accumulator clear
- acc_en  out  1  — MUL3 output valid, accumulate
- acc_last  out  1  — qualifies acc_en for the last batch of the iteration
- upd_start  out  1  — one-cycle pulse, start the w update
- upd_done  in  1  — update finished; ignored outside UPDATE
- converged  in  1  — sampled only when upd_done=1 in UPDATE
- busy  out  1  — state ≠ IDLE
- done  out  1  — one-cycle pulse at run end
- timeout  out  1  — run ended by MAX_ITER; held until the next accepted start
- iter_cnt  out  IT_W  — completed iterations; held after done

## Operation
States:
- **IDLE**: start=1 → CLEAR. Accepting start clears iter_cnt and timeout.
- **CLEAR**: acc_clr=1 for one cycle, batch count reset → STREAM.
- **STREAM**: z_ready=1, so en_mul1 = z_valid & z_ready (combinational).
  - Each accept increments the batch count.
  - The accept with count = N_SAMPLES-1 tags its token "last" and goes to DRAIN.
- **DRAIN**: z_ready=0; wait until the stage-2/3/acc valid bits are all clear, then go to UPDATE and pulse upd_start in the transition cycle.
- **UPDATE**: wait for upd_done; iter_cnt increments on it.
  - converged=1 → DONE, timeout=0.
  - Else, if the new iter_cnt = MAX_ITER → DONE, timeout=1.
  - Else → CLEAR.
- **DONE**: done=1 for one cycle → IDLE.

Token pipe:
- Three registered valid bits v2, v3, va, each carrying a last flag.
- v2 ← en_mul1, v3 ← v2, va ← v3.
- en_mul2 = v2, en_mul3 = v3, acc_en = va, acc_last = va & last_a.
- Gaps (z_valid low) travel as bubbles. The MUL stages' z pass-through stays aligned because the enables follow the token.

Boundary rules:
- start while busy is ignored.
- z_valid while z_ready=0 is not accepted; no en_mul1.
- abort: state → IDLE, all valid bits, counters and pulses cleared next cycle, no done pulse. abort wins over a simultaneous start or upd_done.
- N_SAMPLES=1: the single accept goes straight to DRAIN.
- upd_done in the same cycle as upd_start is impossible (UPDATE not yet entered) and is ignored.

## Timing
- Reset: state IDLE; z_ready, all enables, acc_clr, acc_en, acc_last, upd_start, busy, done, timeout = 0; iter_cnt = 0; counters and valid bits 0.
- Accept at cycle t: en_mul1 at t, en_mul2 at t+1, en_mul3 at t+2, acc_en at t+3.
- Last accept at t: DRAIN from t+1; acc_last at t+3; upd_start at t+4; UPDATE from t+5.
- start at t: acc_clr at t+1, z_ready from t+2.
- upd_done at u (not final): acc_clr at u+1, z_ready at u+2.
- upd_done at u (final): done at u+1, busy low at u+2.
- Throughput: one batch per cycle in STREAM.

## Structure
- Shared package ica_ctrl_pkg holds the state encoding (IDLE, CLEAR, STREAM, DRAIN, UPDATE, DONE) and the default N_SAMPLES/MAX_ITER constants used by the top level and the bench.
- One sub-module, one_unit_vpipe: the 3-deep valid+last shift register with synchronous flush (driven by abort) and an "empty" output used by DRAIN.
- The FSM and counters stay in one_unit_seq.

## Test plan
All scenarios use N_SAMPLES=4, MAX_ITER=3 unless noted.
- **Continuous stream**: start, z_valid held high, converged=1 on the first upd_done. Expect 4 en_mul1 cycles back-to-back; acc_en on 4 consecutive cycles with acc_last on the 4th; one upd_start; done with iter_cnt=1, timeout=0.
- **Bubbles**: z_valid pattern 1,0,1,1,0,1. Expect en_mul2/en_mul3/acc_en to reproduce the pattern delayed by 1/2/3 cycles, and acc_last exactly on the 4th token.
- **Timeout**: converged always 0. Expect 3 CLEAR/STREAM/UPDATE loops, 3 acc_clr pulses, done with iter_cnt=3, timeout=1 held until the next start.
- **Abort mid-DRAIN** (one token in flight): expect no acc_en next cycle, busy=0, done never asserted. A following start runs cleanly with iter_cnt restarting at 0.
- **Spurious inputs**: start during STREAM and upd_done during STREAM. Expect no state change and the batch count unaffected.
- **Reset**: rst_n low asynchronously mid-STREAM. Expect all outputs 0 immediately, without waiting for a clock edge.
